// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage, directly downstream of the ALU.
// Takes the ALU result as an effective address or as writeback data.
// Issues byte-masked loads and stores on the data memory port.
// Aligns and extends load data, and presents a registered writeback bundle.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   Defined   : adds output misalign_fault. A misaligned half/word access
//               issues no memory request. It retires on the next cycle with
//               wb_regf_we=0, wb_rd_v=ex_aluout and misalign_fault=1.
//   Undefined : no alignment check. The truncated byte masks are issued as
//               computed.
//
// Handshake: ex_valid is the upstream valid, and ~mem_stall is the ready
// returned to it. A bundle is consumed on a rising edge where
// ex_valid=1 and mem_stall=0. While mem_stall=1, upstream holds every ex_*
// input stable. A memory access is therefore read straight from the held
// ex_* inputs for its whole lifetime, and no copy is kept here.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluout,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs2_v,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_regf_we,
    output logic        mem_stall,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_rd_v,
    output logic        wb_regf_we,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output logic        dbg_state
);

    // IDLE: accepting bundles. WAIT: one memory access outstanding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd_addr;
    logic [31:0] r_wb_rd_v;
    logic        r_wb_regf_we;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        r_misalign_fault;
`endif

    logic [1:0]  w_off;       // byte offset within the addressed word
    logic [4:0]  w_shamt;     // lane shift in bits (8 * offset)
    logic        w_f3_ok;     // funct3 is one of lb/lh/lw/lbu/lhu
    logic        w_is_mem;    // bundle asks for a memory access at all
    logic        w_legal;     // exactly one of read/write, and a legal width
    logic        w_misalign;  // misaligned half/word (trap build only)
    logic        w_issue;     // a request goes out on the port this cycle
    logic        w_rd_we;     // register write enable, with x0 suppressed
    logic [3:0]  w_mask;      // byte lanes touched by this access
    logic [31:0] w_rshift;    // read data shifted down to lane 0
    logic [31:0] w_load;      // aligned and extended load result

    assign w_off    = ex_aluout[1:0];
    assign w_shamt  = {w_off, 3'b000};
    assign w_is_mem = ex_mem_read | ex_mem_write;
    assign w_legal  = w_f3_ok & (ex_mem_read ^ ex_mem_write);
    assign w_rd_we  = ex_regf_we & (ex_rd_addr != 5'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    // A half access needs an even offset, and a word access needs offset 0.
    assign w_misalign = ((ex_funct3[1:0] == 2'b01) & w_off[0]) |
                        ((ex_funct3[1:0] == 2'b10) & (w_off != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // A request is only issued from IDLE, so masks last exactly one cycle.
    assign w_issue = (r_state == ST_IDLE) & ex_valid & w_is_mem & w_legal & ~w_misalign;

    // Decode which funct3 codes describe a real load/store width.
    always_comb begin
        w_f3_ok = 1'b0;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
            default:                                w_f3_ok = 1'b0;
        endcase
    end

    // Build the byte-lane mask. The shifts are 4 bits wide and drop lanes that
    // fall off the top of the word.
    always_comb begin
        w_mask = 4'b0000;
        case (ex_funct3[1:0])
            2'b00:   w_mask = 4'b0001 << w_off;
            2'b01:   w_mask = 4'b0011 << w_off;
            2'b10:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    // Shift the read data down to lane 0, then sign- or zero-extend it by width.
    always_comb begin
        w_rshift = dmem_rdata >> w_shamt;
        w_load   = w_rshift;
        case (ex_funct3)
            3'b000:  w_load = {{24{w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_load = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b010:  w_load = w_rshift;
            3'b100:  w_load = {24'h000000, w_rshift[7:0]};
            3'b101:  w_load = {16'h0000, w_rshift[15:0]};
            default: w_load = w_rshift;
        endcase
    end

    // The memory port follows the held ex_* inputs. Masks are gated by the
    // issue cycle.
    assign dmem_addr  = {ex_aluout[31:2], 2'b00};
    assign dmem_wdata = ex_rs2_v << w_shamt;
    assign dmem_rmask = (w_issue & ex_mem_read)  ? w_mask : 4'b0000;
    assign dmem_wmask = (w_issue & ex_mem_write) ? w_mask : 4'b0000;

    // Stall from the issue cycle until the cycle in which the response arrives.
    assign mem_stall = w_issue | ((r_state == ST_WAIT) & ~dmem_resp);

    // Sequence memory accesses and register the writeback bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wb_valid   <= 1'b0;
            r_wb_rd_addr <= 5'd0;
            r_wb_rd_v    <= 32'd0;
            r_wb_regf_we <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign_fault <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign_fault <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!ex_valid) begin
                        // Bubble: nothing retires.
                        r_wb_valid   <= 1'b0;
                        r_wb_regf_we <= 1'b0;
                    end else if (w_issue) begin
                        // The access is on the port now. Writeback waits for the response.
                        r_state      <= ST_WAIT;
                        r_wb_valid   <= 1'b0;
                        r_wb_regf_we <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                    end else if (w_is_mem && w_legal && w_misalign) begin
                        // Trapped misaligned access retires at once, with no register write.
                        r_wb_valid       <= 1'b1;
                        r_wb_rd_addr     <= ex_rd_addr;
                        r_wb_rd_v        <= ex_aluout;
                        r_wb_regf_we     <= 1'b0;
                        r_misalign_fault <= 1'b1;
`endif
                    end else if (w_is_mem) begin
                        // Illegal width, or both read and write set: retire as a bubble.
                        r_wb_valid   <= 1'b0;
                        r_wb_regf_we <= 1'b0;
                    end else begin
                        // Plain ALU result passes straight through to writeback.
                        r_wb_valid   <= 1'b1;
                        r_wb_rd_addr <= ex_rd_addr;
                        r_wb_rd_v    <= ex_aluout;
                        r_wb_regf_we <= w_rd_we;
                    end
                end
                ST_WAIT: begin
                    if (dmem_resp) begin
                        // Access done. A load writes its data back; a store only retires.
                        r_state      <= ST_IDLE;
                        r_wb_valid   <= 1'b1;
                        r_wb_rd_addr <= ex_rd_addr;
                        r_wb_rd_v    <= ex_mem_read ? w_load : ex_aluout;
                        r_wb_regf_we <= ex_mem_read & w_rd_we;
                    end else begin
                        r_wb_valid   <= 1'b0;
                        r_wb_regf_we <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_wb_valid   <= 1'b0;
                    r_wb_regf_we <= 1'b0;
                end
            endcase
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_rd_addr = r_wb_rd_addr;
    assign wb_rd_v    = r_wb_rd_v;
    assign wb_regf_we = r_wb_regf_we;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_fault = r_misalign_fault;
`endif
    assign dbg_state  = (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Expected writebacks are queued when a bundle is driven.
// A negedge monitor pops the queue and compares each wb_valid beat against it.
module tb_mem_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ex_valid = 0;
  logic [31:0] ex_aluout = 0;
  logic        ex_mem_read = 0;
  logic        ex_mem_write = 0;
  logic [2:0]  ex_funct3 = 0;
  logic [31:0] ex_rs2_v = 0;
  logic [4:0]  ex_rd_addr = 0;
  logic        ex_regf_we = 0;
  logic        mem_stall;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 0;
  logic        dmem_resp = 0;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_v;
  logic        wb_regf_we;
  logic        dbg_state;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_rs2_v(ex_rs2_v),
    .ex_rd_addr(ex_rd_addr), .ex_regf_we(ex_regf_we),
    .mem_stall(mem_stall), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .wb_rd_v(wb_rd_v), .wb_regf_we(wb_regf_we),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_fault(misalign_fault),
`endif
    .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic allow_stray = 1'b0;

  // ---------------- scoreboard ----------------
  // entry: {check_value, misalign, rd_addr[4:0], rd_v[31:0], regf_we}
  logic [39:0] exp_q[$];
  logic [39:0] sb_e;
  logic        sb_mis;

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
`ifdef MEM_MISALIGN_TRAP_EN
      sb_mis = misalign_fault;
`else
      sb_mis = 1'b0;
`endif
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_wb got rd=%0d v=%h we=%0b want no writeback",
                 wb_rd_addr, wb_rd_v, wb_regf_we);
      end else begin
        sb_e = exp_q.pop_front();
        if ((wb_rd_addr !== sb_e[37:33]) || (wb_regf_we !== sb_e[0]) ||
            (sb_mis !== sb_e[38]) || (sb_e[39] && (wb_rd_v !== sb_e[32:1]))) begin
          errors++;
          $display("FAIL sb_wb got rd=%0d v=%h we=%0b mis=%0b want rd=%0d v=%h we=%0b mis=%0b",
                   wb_rd_addr, wb_rd_v, wb_regf_we, sb_mis,
                   sb_e[37:33], sb_e[32:1], sb_e[0], sb_e[38]);
        end
      end
    end
    // A response while the DUT is idle is a protocol error unless a test injects it on purpose.
    if (!rst && dmem_resp && !allow_stray && (dbg_state == 1'b0)) begin
      checks++;
      errors++;
      $display("FAIL protocol_resp_in_idle got dbg_state=%0b want 1", dbg_state);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] mdl_mask(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00: case (o) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                      2'd2: return 4'b0100; default: return 4'b1000; endcase
      2'b01: case (o) 2'd0: return 4'b0011; 2'd1: return 4'b0110;
                      2'd2: return 4'b1100; default: return 4'b1000; endcase
      2'b10: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [1:0] o, input logic [31:0] d);
    case (o)
      2'd0: return d;
      2'd1: return {d[23:0], 8'h00};
      2'd2: return {d[15:0], 16'h0000};
      default: return {d[7:0], 24'h000000};
    endcase
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] d);
    logic [7:0] b; logic [15:0] h; logic [31:0] w;
    case (o)
      2'd0: begin b = d[7:0];   h = d[15:0];           w = d; end
      2'd1: begin b = d[15:8];  h = d[23:8];           w = {8'h00, d[31:8]}; end
      2'd2: begin b = d[23:16]; h = d[31:16];          w = {16'h0000, d[31:16]}; end
      default: begin b = d[31:24]; h = {8'h00, d[31:24]}; w = {24'h000000, d[31:24]}; end
    endcase
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b001: return {{16{h[15]}}, h};
      3'b100: return {24'h000000, b};
      3'b101: return {16'h0000, h};
      default: return w;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_regf_we = 0;
  endtask

  // Issue one memory access and answer it after 'delay' idle wait cycles.
  // Returns what the port showed on the issue cycle, the number of cycles mem_stall was high,
  // and whether any mask was seen during the wait. Ends one cycle after the response,
  // when the writeback is visible.
  task automatic issue_mem(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int delay,
                           input logic [4:0] rd, input logic we,
                           output logic [3:0] rmask_s, output logic [3:0] wmask_s,
                           output logic [31:0] addr_s, output logic [31:0] wdata_s,
                           output int stall_n, output logic wait_mask);
    ex_valid = 1; ex_aluout = addr; ex_mem_read = rd_op; ex_mem_write = wr_op;
    ex_funct3 = f3; ex_rs2_v = rs2; ex_rd_addr = rd; ex_regf_we = we;
    #1;
    rmask_s = dmem_rmask; wmask_s = dmem_wmask; addr_s = dmem_addr; wdata_s = dmem_wdata;
    stall_n = mem_stall ? 1 : 0;
    wait_mask = 1'b0;
    for (int w = 1; w <= delay + 1; w++) begin
      tick();
      if (w == delay + 1) begin
        dmem_resp = 1; dmem_rdata = rdata;
      end else begin
        dmem_rdata = $urandom;
      end
      #1;
      if (dmem_rmask != 4'b0000 || dmem_wmask != 4'b0000) wait_mask = 1'b1;
      if (mem_stall) stall_n++;
    end
    tick();
    dmem_resp = 0;
    clear_ex();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; clear_ex();
    repeat (3) tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0b want=0", wb_valid); end
    checks++; if (wb_regf_we !== 1'b0) begin errors++; $display("FAIL reset_wb_regf_we got=%0b want=0", wb_regf_we); end
    checks++; if (wb_rd_v !== 32'd0 || wb_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_wb_data got v=%h rd=%0d want 0/0", wb_rd_v, wb_rd_addr); end
    checks++; if (dmem_rmask !== 4'b0 || dmem_wmask !== 4'b0) begin errors++; $display("FAIL reset_masks got r=%b w=%b want 0000/0000", dmem_rmask, dmem_wmask); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b want=0", mem_stall); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got=%0b want=0", dbg_state); end
    rst = 0;
    tick();
  endtask

  task automatic test_passthrough();
    ex_valid = 1; ex_aluout = 32'h1234; ex_rd_addr = 5; ex_regf_we = 1;
    ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 3'b010;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL pass_stall got=%0b want=0", mem_stall); end
    exp_q.push_back({1'b1, 1'b0, 5'd5, 32'h1234, 1'b1});
    tick();
    clear_ex();
    checks++; if (wb_valid !== 1'b1 || wb_rd_v !== 32'h1234) begin errors++; $display("FAIL pass_wb got valid=%0b v=%h want 1/00001234", wb_valid, wb_rd_v); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] rd; logic we; logic [31:0] v;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble got=%0b want=0", wb_valid); end
      end
      if (i == 4) begin
        clear_ex();
      end else begin
        rd = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1)); v = $urandom;
        ex_valid = 1; ex_aluout = v; ex_rd_addr = rd; ex_regf_we = we;
        ex_mem_read = 0; ex_mem_write = 0;
        exp_q.push_back({1'b1, 1'b0, rd, v, we && (rd != 5'd0)});
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got=%0b want=0", mem_stall); end
      end
      tick();
    end
    clear_ex();
    tick();
  endtask

  task automatic test_lb();
    logic [3:0] rm, wm; logic [31:0] a, wd; int st; logic wmk;
    exp_q.push_back({1'b1, 1'b0, 5'd7, 32'hFFFF_FF80, 1'b1});
    issue_mem(1, 0, 3'b000, 32'h1003, 0, 32'h80FF_FF00, 3, 7, 1, rm, wm, a, wd, st, wmk);
    checks++; if (rm !== 4'b1000 || wm !== 4'b0000) begin errors++; $display("FAIL lb_mask got r=%b w=%b want 1000/0000", rm, wm); end
    checks++; if (a !== 32'h1000) begin errors++; $display("FAIL lb_addr got=%h want=00001000", a); end
    checks++; if (st != 4) begin errors++; $display("FAIL lb_stall_cycles got=%0d want=4", st); end
    checks++; if (wmk !== 1'b0) begin errors++; $display("FAIL lb_wait_mask got=%0b want=0", wmk); end
    checks++; if (wb_valid !== 1'b1 || wb_rd_v !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb got valid=%0b v=%h want 1/ffffff80", wb_valid, wb_rd_v); end
    tick();
  endtask

  task automatic test_lhu();
    logic [3:0] rm, wm; logic [31:0] a, wd; int st; logic wmk;
    exp_q.push_back({1'b1, 1'b0, 5'd9, 32'h0000_BEEF, 1'b1});
    issue_mem(1, 0, 3'b101, 32'h2002, 0, 32'hBEEF_0000, 0, 9, 1, rm, wm, a, wd, st, wmk);
    checks++; if (rm !== 4'b1100) begin errors++; $display("FAIL lhu_mask got=%b want=1100", rm); end
    checks++; if (st != 1) begin errors++; $display("FAIL lhu_stall_cycles got=%0d want=1", st); end
    checks++; if (wb_rd_v !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_wb got=%h want=0000beef", wb_rd_v); end
    tick();
  endtask

  task automatic test_sb();
    logic [3:0] rm, wm; logic [31:0] a, wd; int st; logic wmk;
    exp_q.push_back({1'b0, 1'b0, 5'd3, 32'h0, 1'b0});
    issue_mem(0, 1, 3'b000, 32'h3001, 32'hAB, 0, $urandom_range(0, 2), 3, 1, rm, wm, a, wd, st, wmk);
    checks++; if (wm !== 4'b0010 || rm !== 4'b0000) begin errors++; $display("FAIL sb_mask got w=%b r=%b want 0010/0000", wm, rm); end
    checks++; if (wd !== 32'h0000_AB00) begin errors++; $display("FAIL sb_wdata got=%h want=0000ab00", wd); end
    checks++; if (wb_valid !== 1'b1 || wb_regf_we !== 1'b0) begin errors++; $display("FAIL sb_wb got valid=%0b we=%0b want 1/0", wb_valid, wb_regf_we); end
    tick();
  endtask

  task automatic test_rd_zero();
    logic [3:0] rm, wm; logic [31:0] a, wd, d; int st; logic wmk;
    d = $urandom;
    exp_q.push_back({1'b1, 1'b0, 5'd0, d, 1'b0});
    issue_mem(1, 0, 3'b010, 32'h40, 0, d, 1, 0, 1, rm, wm, a, wd, st, wmk);
    checks++; if (rm !== 4'b1111) begin errors++; $display("FAIL rd0_mask got=%b want=1111", rm); end
    checks++; if (wb_valid !== 1'b1 || wb_regf_we !== 1'b0) begin errors++; $display("FAIL rd0_we got valid=%0b we=%0b want 1/0", wb_valid, wb_regf_we); end
    tick();
  endtask

  task automatic test_random_mem();
    logic [3:0] rm, wm; logic [31:0] a, wd, d, rs2, base; int st, dly; logic wmk;
    logic [2:0] f3; logic [1:0] o; logic [4:0] rd; logic st_op;
    logic [2:0] ld_tbl[5];
    ld_tbl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 14; i++) begin
      st_op = 1'($urandom_range(0, 1));
      f3 = st_op ? 3'($urandom_range(0, 2)) : ld_tbl[$urandom_range(0, 4)];
      case (f3[1:0])
        2'b00:   o = 2'($urandom_range(0, 3));
        2'b01:   o = {1'($urandom_range(0, 1)), 1'b0};
        default: o = 2'b00;
      endcase
      base = $urandom; base[1:0] = o;
      d = $urandom; rs2 = $urandom; rd = 5'($urandom_range(1, 31));
      dly = $urandom_range(0, 3);
      exp_q.push_back({!st_op, 1'b0, rd, st_op ? 32'h0 : mdl_load(f3, o, d), !st_op});
      issue_mem(!st_op, st_op, f3, base, rs2, d, dly, rd, 1, rm, wm, a, wd, st, wmk);
      checks++;
      if ((st_op ? wm : rm) !== mdl_mask(f3, o) || (st_op ? rm : wm) !== 4'b0000 ||
          a !== {base[31:2], 2'b00} || st != dly + 1 || wmk !== 1'b0 ||
          (st_op && wd !== mdl_wdata(o, rs2))) begin
        errors++;
        $display("FAIL rand_mem[%0d] got r=%b w=%b a=%h wd=%h st=%0d wm=%0b want mask=%b a=%h wd=%h st=%0d",
                 i, rm, wm, a, wd, st, wmk, mdl_mask(f3, o), {base[31:2], 2'b00},
                 mdl_wdata(o, rs2), dly + 1);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [4:0] tbl[4];   // {read, write, funct3}
    tbl = '{5'b10_011, 5'b01_110, 5'b11_010, 5'b10_111};
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1; ex_mem_read = tbl[i][4]; ex_mem_write = tbl[i][3]; ex_funct3 = tbl[i][2:0];
      ex_aluout = $urandom; ex_rd_addr = 4; ex_regf_we = 1;
      #1;
      checks++;
      if (mem_stall !== 1'b0 || dmem_rmask !== 4'b0 || dmem_wmask !== 4'b0) begin
        errors++;
        $display("FAIL illegal_req[%0d] got stall=%0b r=%b w=%b want 0/0000/0000", i, mem_stall, dmem_rmask, dmem_wmask);
      end
      tick();
      clear_ex();
      checks++;
      if (wb_valid !== 1'b0 || wb_regf_we !== 1'b0) begin
        errors++;
        $display("FAIL illegal_wb[%0d] got valid=%0b we=%0b want 0/0", i, wb_valid, wb_regf_we);
      end
    end
    tick();
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
    ex_aluout = 32'h42; ex_rd_addr = 6; ex_regf_we = 1;
    #1;
    checks++; if (dmem_rmask !== 4'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL mis_lw_req got r=%b stall=%0b want 0000/0", dmem_rmask, mem_stall); end
    exp_q.push_back({1'b1, 1'b1, 5'd6, 32'h42, 1'b0});
    tick();
    clear_ex();
    checks++; if (misalign_fault !== 1'b1 || wb_valid !== 1'b1 || wb_regf_we !== 1'b0) begin errors++; $display("FAIL mis_lw_wb got fault=%0b valid=%0b we=%0b want 1/1/0", misalign_fault, wb_valid, wb_regf_we); end
    tick();
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%0b want=0", misalign_fault); end
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 1; ex_funct3 = 3'b001;
    ex_aluout = 32'h1001; ex_rd_addr = 2; ex_regf_we = 0;
    #1;
    checks++; if (dmem_wmask !== 4'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL mis_sh_req got w=%b stall=%0b want 0000/0", dmem_wmask, mem_stall); end
    exp_q.push_back({1'b1, 1'b1, 5'd2, 32'h1001, 1'b0});
    tick();
    clear_ex();
    tick();
  endtask
`else
  task automatic test_misalign();
    logic [3:0] rm, wm; logic [31:0] a, wd, d; int st; logic wmk;
    d = $urandom;
    exp_q.push_back({1'b1, 1'b0, 5'd6, mdl_load(3'b010, 2'd2, d), 1'b1});
    issue_mem(1, 0, 3'b010, 32'h42, 0, d, 0, 6, 1, rm, wm, a, wd, st, wmk);
    checks++; if (rm !== 4'b1111) begin errors++; $display("FAIL trunc_lw_mask got=%b want=1111", rm); end
    tick();
    d = $urandom;
    exp_q.push_back({1'b1, 1'b0, 5'd11, mdl_load(3'b001, 2'd3, d), 1'b1});
    issue_mem(1, 0, 3'b001, 32'h2003, 0, d, 1, 11, 1, rm, wm, a, wd, st, wmk);
    checks++; if (rm !== 4'b1000 || st != 2) begin errors++; $display("FAIL trunc_lh got mask=%b st=%0d want 1000/2", rm, st); end
    tick();
  endtask
`endif

  task automatic test_reset_in_wait();
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
    ex_aluout = 32'h500; ex_rd_addr = 8; ex_regf_we = 1;
    tick();
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL rstwait_entered got=%0b want=1", dbg_state); end
    rst = 1;
    tick();
    rst = 0; clear_ex();
    allow_stray = 1; dmem_resp = 1; dmem_rdata = $urandom;
    #1;
    checks++; if (dbg_state !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rstwait_idle got st=%0b stall=%0b valid=%0b want 0/0/0", dbg_state, mem_stall, wb_valid); end
    tick();
    dmem_resp = 0;
    checks++; if (wb_valid !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL rstwait_stray got valid=%0b st=%0b want 0/0", wb_valid, dbg_state); end
    tick();
    allow_stray = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_lb();
    test_lhu();
    test_sb();
    test_rd_zero();
    test_random_mem();
    test_illegal();
    test_misalign();
    test_reset_in_wait();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
